// File: rtl/vtg_register_arbiter.sv
// vtg_register_arbiter
//   Round-robin write arbiter sharing one vtg_register between four
//   requesters, with optional bounded bursts for a locked winner.
//
//   Ports:
//     clk    - single clock, rising edge
//     rst    - synchronous active-low reset
//     req    - [3:0] per-requester write request (level, held until ack)
//     lock   - [3:0] per-requester burst request, sampled in ACK
//     wdata  - [4*SIZE-1:0] flat data, requester i owns wdata[i*SIZE +: SIZE]
//     gnt    - [3:0] one-hot grant, high only in WRITE
//     ack    - [3:0] one-hot completion pulse, high only in ACK
//     q      - [SIZE-1:0] shared register contents
//     busy   - high whenever the arbiter is not IDLE
//
// vtg_register
//   Plain write-enabled register with synchronous active-low reset.
//
//   Ports:
//     clk, rst - clock and synchronous active-low reset
//     we       - write enable
//     datain   - [SIZE-1:0] write data
//     dataout  - [SIZE-1:0] register contents

module vtg_register #(
    parameter int              SIZE    = 8,
    parameter logic [SIZE-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [SIZE-1:0] datain,
    output logic [SIZE-1:0] dataout
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            dataout <= RST_VAL;
        end else if (we) begin
            dataout <= datain;
        end
    end

endmodule

module vtg_register_arbiter #(
    parameter int              SIZE      = 8,
    parameter logic [SIZE-1:0] RST_VAL   = '0,
    parameter int              MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [3:0]        lock,
    input  logic [4*SIZE-1:0] wdata,
    output logic [3:0]        gnt,
    output logic [3:0]        ack,
    output logic [SIZE-1:0]   q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK
    } state_t;

    localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);

    state_t          state;
    logic [1:0]      winner;
    logic [1:0]      ptr;
    logic [3:0]      burst_cnt;
    logic [1:0]      pick;
    logic [1:0]      idx;
    logic            found;
    logic            we;
    logic [SIZE-1:0] datain;
    logic            stay;

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Round-robin search starting at ptr; first requester found wins.
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign we     = (state == WRITE);
    assign datain = wdata[winner*SIZE +: SIZE];

    // Burst continues only while the winner still holds lock and req and
    // the next write would not exceed MAX_BURST.
    assign stay = lock[winner] && req[winner] &&
                  (({1'b0, burst_cnt} + 5'd1) < BURST_LIM);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            winner    <= 2'd0;
            ptr       <= 2'd0;
            burst_cnt <= '0;
            gnt       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        winner <= pick;
                        gnt    <= onehot(pick);
                        busy   <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    gnt   <= '0;
                    ack   <= onehot(winner);
                    state <= ACK;
                end
                ACK: begin
                    ack <= '0;
                    if (stay) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        gnt       <= onehot(winner);
                        state     <= WRITE;
                    end else begin
                        burst_cnt <= '0;
                        ptr       <= winner + 2'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    vtg_register #(
        .SIZE    (SIZE),
        .RST_VAL (RST_VAL)
    ) u_reg (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .datain  (datain),
        .dataout (q)
    );

endmodule

// File: tb/tb_vtg_register_arbiter.sv
module tb_vtg_register_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, lock, gnt, ack;
    logic [31:0] wdata;
    logic [7:0]  q;
    logic        busy;

    logic [3:0]  reqb, lockb, gntb, ackb;
    logic [31:0] wdatab;
    logic [7:0]  qb;
    logic        busyb;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t sb2[$];
    exp_t e1, e2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vtg_register_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .busy  (busy)
    );

    vtg_register_arbiter #(
        .SIZE      (8),
        .RST_VAL   (8'hA5),
        .MAX_BURST (1)
    ) dut_b (
        .clk   (clk),
        .rst   (rst),
        .req   (reqb),
        .lock  (lockb),
        .wdata (wdatab),
        .gnt   (gntb),
        .ack   (ackb),
        .q     (qb),
        .busy  (busyb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every ack must match the next expected (ack, q) pair.
    always @(negedge clk) begin
        if (ack != 4'd0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", {28'd0, ack}, 32'd0);
            end else begin
                e1 = sb.pop_front();
                chk("sb_ack", {28'd0, ack}, {28'd0, e1.a});
                chk("sb_q", {24'd0, q}, {24'd0, e1.d});
            end
        end
        if (ackb != 4'd0) begin
            if (sb2.size() == 0) begin
                chk("ackb_unexpected", {28'd0, ackb}, 32'd0);
            end else begin
                e2 = sb2.pop_front();
                chk("sb2_ack", {28'd0, ackb}, {28'd0, e2.a});
                chk("sb2_q", {24'd0, qb}, {24'd0, e2.d});
            end
        end
    end

    initial begin
        int n, gi, acks, last;

        rst = 1'b0; req = '0; lock = '0; wdata = '0;
        reqb = '0; lockb = '0; wdatab = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_qb_rstval", {24'd0, qb}, 32'hA5);
        chk("rst_busyb", {31'd0, busyb}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single requester, latency
        wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
        req = 4'b0010;
        sb.push_back({4'b0010, 8'h3C});
        @(negedge clk);
        chk("single_gnt", {28'd0, gnt}, 32'b0010);
        chk("single_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("single_ack", {28'd0, ack}, 32'b0010);
        chk("single_gnt_off", {28'd0, gnt}, 32'd0);
        req = '0;
        @(negedge clk);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // Reset returns ptr to 0 before the round-robin sweep
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // All four requesting
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'hF;
        sb.push_back({4'b0001, 8'h11});
        sb.push_back({4'b0010, 8'h22});
        sb.push_back({4'b0100, 8'h33});
        sb.push_back({4'b1000, 8'h44});
        n = 0; gi = 0;
        do begin
            @(negedge clk);
            n++;
            if (gnt != 4'd0) begin
                if (gi < 4) chk("rr_gnt", {28'd0, gnt}, 32'(1 << gi));
                else chk("rr_extra_gnt", {28'd0, gnt}, 32'd0);
                gi++;
            end
            req = req & ~ack;
        end while ((busy || req != 4'd0) && n < 40);
        chk("rr_cycles", n, 12);
        chk("rr_grants", gi, 4);

        // Fairness: 0 and 3 keep requesting; first grant 0 implies ptr wrapped to 0
        wdata = {8'hC3, 8'h00, 8'h00, 8'h5A};
        req = 4'b1001;
        repeat (2) begin
            sb.push_back({4'b0001, 8'h5A});
            sb.push_back({4'b1000, 8'hC3});
        end
        acks = 0; n = 0;
        while (acks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack != 4'd0) begin
                acks++;
                if (acks == 4) req = '0;
            end
        end
        chk("fair_acks", acks, 4);
        @(negedge clk);
        chk("fair_idle", {31'd0, busy}, 32'd0);

        // Locked burst on requester 2, requester 0 waiting
        wdata = {8'h00, 8'h6B, 8'h00, 8'h0D};
        req = 4'b0100; lock = 4'b0100;
        repeat (4) sb.push_back({4'b0100, 8'h6B});
        sb.push_back({4'b0001, 8'h0D});
        @(negedge clk);
        chk("lock_gnt", {28'd0, gnt}, 32'b0100);
        req = 4'b0101;
        acks = 0; last = 0; n = 0;
        while (acks < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack != 4'd0) begin
                acks++;
                if (acks >= 2 && acks <= 4) chk("burst_spacing", n - last, 2);
                last = n;
                if (acks == 4) begin
                    req = 4'b0001; lock = '0;
                    @(negedge clk);
                    n++;
                    chk("burst_idle", {31'd0, busy}, 32'd0);
                end
                if (acks == 5) req = '0;
            end
        end
        chk("lock_acks", acks, 5);
        @(negedge clk);

        // MAX_BURST=1: lock has no effect, requester 0 gets the next grant
        wdatab = {8'h00, 8'h77, 8'h00, 8'h99};
        reqb = 4'b0100; lockb = 4'b0100;
        sb2.push_back({4'b0100, 8'h77});
        sb2.push_back({4'b0001, 8'h99});
        @(negedge clk);
        chk("b_gnt", {28'd0, gntb}, 32'b0100);
        reqb = 4'b0101;
        acks = 0; n = 0;
        while (acks < 2 && n < 40) begin
            @(negedge clk);
            n++;
            if (ackb != 4'd0) begin
                acks++;
                if (acks == 2) begin reqb = '0; lockb = '0; end
            end
        end
        chk("b_acks", acks, 2);
        @(negedge clk);

        // Requester 2 write moves ptr to 3
        wdata = {8'h00, 8'h24, 8'h00, 8'h00};
        req = 4'b0100;
        sb.push_back({4'b0100, 8'h24});
        n = 0;
        while (ack == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_abort_ack", {28'd0, ack}, 32'b0100);
        req = '0;
        @(negedge clk);

        // Reset during WRITE of requester 3 aborts it
        wdata = {8'hFF, 8'h00, 8'h42, 8'h00};
        req = 4'b1010;
        @(negedge clk);
        chk("abort_gnt", {28'd0, gnt}, 32'b1000);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ack", {28'd0, ack}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_gnt_off", {28'd0, gnt}, 32'd0);
        chk("abort_qb", {24'd0, qb}, 32'hA5);
        rst = 1'b1;
        // ptr back at 0, so requester 1 wins over 3
        sb.push_back({4'b0010, 8'h42});
        @(negedge clk);
        chk("post_abort_gnt", {28'd0, gnt}, 32'b0010);
        n = 0;
        while (ack == 4'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_abort_ack", {28'd0, ack}, 32'b0010);
        req = '0;
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        chk("sb2_empty", sb2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
